// File: rtl/pkg_config.sv
// Shared configuration for the core's data-side blocks: data width, LSU FSM
// states and RV32I load/store funct3 encodings.
package pkg_config;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } lsu_state_t;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  // 011, 110 and 111 have no load/store meaning in RV32I.
  function automatic logic lsu_f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// load_store_align: combinational lane logic for the LSU.
// Produces the extended load value, the read-modify-write merged store word
// and the misalign flag. Lane selection always uses the size-aligned offset,
// so a misaligned access that is allowed through acts on the aligned lane.
module load_store_align
  import pkg_config::*;
(
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] rword,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] merged,
  output logic                  misalign
);

  logic [1:0]  lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Misalign detection and forced-alignment lane offset.
  always_comb begin
    misalign = 1'b0;
    lane     = addr_lo;
    case (funct3[1:0])
      2'b01: begin
        misalign = addr_lo[0];
        lane     = {addr_lo[1], 1'b0};
      end
      2'b10: begin
        misalign = |addr_lo;
        lane     = 2'b00;
      end
      default: ;
    endcase
  end

  // Lane extraction and sign/zero extension for loads.
  always_comb begin
    byte_v   = rword[{lane, 3'b000} +: 8];
    half_v   = lane[1] ? rword[31:16] : rword[15:0];
    load_val = rword;
    case (funct3)
      LSU_F3_B:  load_val = {{24{byte_v[7]}}, byte_v};
      LSU_F3_BU: load_val = {24'h0, byte_v};
      LSU_F3_H:  load_val = {{16{half_v[15]}}, half_v};
      LSU_F3_HU: load_val = {16'h0, half_v};
      default:   load_val = rword;
    endcase
  end

  // Store merge: overwrite only the addressed lane of the read word.
  always_comb begin
    merged = rword;
    case (funct3[1:0])
      2'b00: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte-addressed loads/stores onto a word-wide
// data_memory without byte enables (sub-word stores are read-modify-write).
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// accesses complete with err_o and no memory access; otherwise the low
// address bits are forced to alignment and the access proceeds.
module load_store_unit
  import pkg_config::*;
#(
  parameter int MEM_SIZE   = 1024,
  parameter int MEM_ADDR_W = $clog2(MEM_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_t                state_q, state_d;
  logic                      we_q;
  logic [2:0]                f3_q;
  logic [MEM_ADDR_W+1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;   // store data, later the merged word
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      err_q;

  logic                      idle;
  logic [2:0]                al_f3;
  logic [1:0]                al_addr;
  logic [DATA_WIDTH-1:0]     load_val;
  logic [DATA_WIDTH-1:0]     merged;
  logic                      misalign;
  logic                      req_err;

  // Address bits above the memory range only wrap, they are never used.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:MEM_ADDR_W+2];

  assign idle = (state_q == IDLE);

  // In IDLE the aligner classifies the incoming request; afterwards it
  // works on the captured request.
  assign al_f3   = idle ? funct3_i    : f3_q;
  assign al_addr = idle ? addr_i[1:0] : addr_q[1:0];

  load_store_align u_align (
    .funct3   (al_f3),
    .addr_lo  (al_addr),
    .rword    (mem_rdata_i),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged),
    .misalign (misalign)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = lsu_f3_illegal(funct3_i) | misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign req_err = lsu_f3_illegal(funct3_i);
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (req_err)                            state_d = DONE;
          else if (we_i && funct3_i[1:0] == 2'b10) state_d = WR;
          else                                    state_d = RD;
        end
      end
      RD:      state_d = RDW;
      RDW:     state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, load result and merged store word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            f3_q    <= funct3_i;
            addr_q  <= addr_i[MEM_ADDR_W+1:0];
            wdata_q <= wdata_i;
            err_q   <= req_err;
          end
        end
        RDW: begin
          if (we_q) wdata_q <= merged;
          else      rdata_q <= load_val;
        end
        default: ;
      endcase
    end
  end

  // Memory port and handshake are decoded purely from registered state.
  assign ready_o     = idle;
  assign valid_o     = (state_q == DONE);
  assign err_o       = valid_o & err_q;
  assign rdata_o     = rdata_q;
  assign mem_we_o    = (state_q == WR);
  assign mem_addr_o  = addr_q[MEM_ADDR_W+1:2];
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data_memory and
// a byte-level reference model. Honours LSU_MISALIGN_TRAP_EN if defined.
module tb_load_store_unit;

  localparam int MEM_SIZE = 64;
  localparam int AW       = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [2:0]    funct3 = 3'b000;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic          ready, valid, err;
  logic [31:0]   rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] mem     [MEM_SIZE];
  logic [31:0] ref_mem [MEM_SIZE];
  logic [31:0] ref_rd = 32'h0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_SIZE(MEM_SIZE), .MEM_ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready), .valid_o(valid),
    .rdata_o(rdata), .err_o(err), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // data_memory: synchronous read, write when we is high.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Drive one request and observe it until valid (bounded).
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic e,
                        output logic [31:0] rd, output int wes, output int we_cyc,
                        output logic [AW-1:0] we_addr, output int busy_rdy);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = $urandom; funct3 = $urandom; addr = $urandom; wdata = $urandom;
    lat = -1; wes = 0; we_cyc = -1; we_addr = '0; e = 1'bx; rd = 'x; busy_rdy = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        wes++;
        if (we_cyc < 0) begin we_cyc = i; we_addr = mem_addr; end
      end
      if (ready === 1'b1) busy_rdy++;
      if (valid === 1'b1) begin lat = i; e = err; rd = rdata; break; end
    end
  endtask

  // Reference model: applies the request at byte level to ref_mem/ref_rd.
  task automatic ref_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic e, output int lat,
                        output int wes, output int widx);
    int unsigned sz, off;
    logic        ill, mis;
    logic [31:0] mask, v;
    ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis  = (a % sz) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    e = ill || mis;
`else
    e = ill;
    a = a - (a % sz);
`endif
    widx = int'((a / 4) % MEM_SIZE);
    off  = a % 4;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
    if (e) begin
      lat = 1; wes = 0;
    end else if (!w) begin
      v = (ref_mem[widx] >> (8 * off)) & mask;
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
      ref_rd = v; lat = 3; wes = 0;
    end else begin
      wes = 1;
      if (sz == 4) begin
        ref_mem[widx] = d; lat = 2;
      end else begin
        ref_mem[widx] = (ref_mem[widx] & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
        lat = 4;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1)      $display("FAIL reset_ready got %b want 1", ready);         else passed++;
    checks++; if (valid !== 1'b0)      $display("FAIL reset_valid got %b want 0", valid);         else passed++;
    checks++; if (err !== 1'b0)        $display("FAIL reset_err got %b want 0", err);             else passed++;
    checks++; if (rdata !== 32'h0)     $display("FAIL reset_rdata got %h want 0", rdata);         else passed++;
    checks++; if (mem_we !== 1'b0)     $display("FAIL reset_mem_we got %b want 0", mem_we);       else passed++;
    checks++; if (mem_addr !== '0)     $display("FAIL reset_mem_addr got %h want 0", mem_addr);   else passed++;
    checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else passed++;
  endtask

  // Fill every memory word with SW; also checks word-store latency.
  task automatic test_fill();
    int lat, wes, wc, br, elat, ewes, widx; logic e, ee; logic [31:0] rd, d; logic [AW-1:0] wa;
    for (int i = 0; i < MEM_SIZE; i++) begin
      d = $urandom;
      run_op(1'b1, 3'b010, i * 4, d, lat, e, rd, wes, wc, wa, br);
      ref_op(1'b1, 3'b010, i * 4, d, ee, elat, ewes, widx);
      checks++; if (lat != 2 || wes != 1) $display("FAIL fill_sw[%0d] lat %0d wes %0d want 2/1", i, lat, wes); else passed++;
    end
  endtask

  task automatic test_load_ext();
    int lat, wes, wc, br, elat, ewes, widx; logic e, ee; logic [31:0] rd; logic [AW-1:0] wa;
    run_op(1'b1, 3'b010, 32'h0, 32'h8000_00F0, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b1, 3'b010, 32'h0, 32'h8000_00F0, ee, elat, ewes, widx);
    run_op(1'b0, 3'b000, 32'h0, 32'h0, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b0, 3'b000, 32'h0, 32'h0, ee, elat, ewes, widx);
    checks++; if (rd !== 32'hFFFF_FFF0 || lat != 3) $display("FAIL lb got %h lat %0d want ffff_fff0 lat 3", rd, lat); else passed++;
    run_op(1'b0, 3'b100, 32'h0, 32'h0, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b0, 3'b100, 32'h0, 32'h0, ee, elat, ewes, widx);
    checks++; if (rd !== 32'h0000_00F0) $display("FAIL lbu got %h want 0000_00f0", rd); else passed++;
    run_op(1'b0, 3'b001, 32'h2, 32'h0, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b0, 3'b001, 32'h2, 32'h0, ee, elat, ewes, widx);
    checks++; if (rd !== 32'hFFFF_8000) $display("FAIL lh got %h want ffff_8000", rd); else passed++;
    run_op(1'b0, 3'b101, 32'h2, 32'h0, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b0, 3'b101, 32'h2, 32'h0, ee, elat, ewes, widx);
    checks++; if (rd !== 32'h0000_8000) $display("FAIL lhu got %h want 0000_8000", rd); else passed++;
  endtask

  task automatic test_stores();
    int lat, wes, wc, br, elat, ewes, widx; logic e, ee; logic [31:0] rd; logic [AW-1:0] wa;
    run_op(1'b1, 3'b010, 32'h4, 32'h1122_3344, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b1, 3'b010, 32'h4, 32'h1122_3344, ee, elat, ewes, widx);
    run_op(1'b1, 3'b000, 32'h5, 32'h0000_00AB, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b1, 3'b000, 32'h5, 32'h0000_00AB, ee, elat, ewes, widx);
    checks++; if (mem[1] !== 32'h1122_AB44) $display("FAIL sb_merge got %h want 1122_ab44", mem[1]); else passed++;
    checks++; if (lat != 4 || wes != 1) $display("FAIL sb_timing lat %0d wes %0d want 4/1", lat, wes); else passed++;
    run_op(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, ee, elat, ewes, widx);
    checks++; if (wc != 1 || wa !== 6'd2) $display("FAIL sw_port we_cycle %0d addr %0d want 1/2", wc, wa); else passed++;
    run_op(1'b0, 3'b010, 32'h8, 32'h0, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b0, 3'b010, 32'h8, 32'h0, ee, elat, ewes, widx);
    checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL lw_after_sw got %h want dead_beef", rd); else passed++;
    // 0x108 wraps to word 2 in a 64-word memory.
    run_op(1'b0, 3'b010, 32'h0000_0108, 32'h0, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b0, 3'b010, 32'h0000_0108, 32'h0, ee, elat, ewes, widx);
    checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL lw_wrap got %h want dead_beef", rd); else passed++;
  endtask

  task automatic test_errors();
    int lat, wes, wc, br, elat, ewes, widx; logic e, ee; logic [31:0] rd; logic [AW-1:0] wa;
    run_op(1'b0, 3'b010, 32'h6, 32'h0, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b0, 3'b010, 32'h6, 32'h0, ee, elat, ewes, widx);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (e !== 1'b1 || lat != 1 || wes != 0 || rd !== 32'hDEAD_BEEF)
      $display("FAIL lw_misalign err %b lat %0d wes %0d rd %h want 1/1/0/dead_beef", e, lat, wes, rd); else passed++;
`else
    checks++; if (e !== 1'b0 || lat != 3 || rd !== 32'h1122_AB44)
      $display("FAIL lw_misalign err %b lat %0d rd %h want 0/3/1122_ab44", e, lat, rd); else passed++;
`endif
    run_op(1'b1, 3'b011, 32'h0, 32'h1234_5678, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b1, 3'b011, 32'h0, 32'h1234_5678, ee, elat, ewes, widx);
    checks++; if (e !== 1'b1 || lat != 1 || wes != 0 || mem[0] !== ref_mem[0])
      $display("FAIL illegal_f3 err %b lat %0d wes %0d want 1/1/0", e, lat, wes); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, wes, wc, br, elat, ewes, widx, bad; logic e, ee; logic [31:0] rd; logic [AW-1:0] wa;
    run_op(1'b1, 3'b010, 32'hC, 32'h5566_7788, lat, e, rd, wes, wc, wa, br);
    ref_op(1'b1, 3'b010, 32'hC, 32'h5566_7788, ee, elat, ewes, widx);
    bad = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'hE; wdata = 32'h0000_BEEF;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk); if (mem_we || valid) bad++;   // RD
    @(negedge clk); if (mem_we || valid) bad++;   // RDW
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; ref_rd = 32'h0;
    checks++; if (ready !== 1'b1 || valid !== 1'b0) $display("FAIL rst_mid_idle ready %b valid %b want 1/0", ready, valid); else passed++;
    repeat (5) begin @(negedge clk); if (mem_we || valid) bad++; end
    checks++; if (bad != 0) $display("FAIL rst_mid_quiet spurious %0d want 0", bad); else passed++;
    checks++; if (mem[3] !== 32'h5566_7788) $display("FAIL rst_mid_mem got %h want 5566_7788", mem[3]); else passed++;
    checks++; if (rdata !== 32'h0) $display("FAIL rst_mid_rdata got %h want 0", rdata); else passed++;
  endtask

  // Back-to-back random loads/stores (legal and illegal) against the model.
  task automatic test_random();
    int lat, wes, wc, br, elat, ewes, widx; logic e, ee, w; logic [31:0] rd, a, d; logic [AW-1:0] wa;
    logic [2:0] f3, st_f3 [6];
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int n = 0; n < 150; n++) begin
      w  = $urandom_range(0, 1);
      f3 = w ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      a  = $urandom; d = $urandom;
      run_op(w, f3, a, d, lat, e, rd, wes, wc, wa, br);
      ref_op(w, f3, a, d, ee, elat, ewes, widx);
      checks++;
      if (lat != elat || e !== ee || rd !== ref_rd || wes != ewes || br != 0 || mem[widx] !== ref_mem[widx])
        $display("FAIL rand[%0d] we %b f3 %0d a %h: lat %0d/%0d err %b/%b rd %h/%h wes %0d/%0d rdy %0d mem %h/%h",
                 n, w, f3, a, lat, elat, e, ee, rd, ref_rd, wes, ewes, br, mem[widx], ref_mem[widx]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load_ext();
    test_stores();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
